// File: rtl/sr04_ranger.sv
// HC-SR04 ultrasonic ranger: fires a trigger pulse, times the echo on the 1 MHz clock,
// converts the width to centimetres by repeated subtraction and enforces a minimum trigger period.
module sr04_ranger #(
  parameter int TRIG_US     = 10,
  parameter int WAIT_US     = 30000,
  parameter int ECHO_MAX_US = 38000,
  parameter int PERIOD_US   = 60000
) (
  input  logic        clk_1m,
  input  logic        rst_n,
  input  logic        start,
  input  logic        auto_en,
  input  logic        s1_echo,
  output logic        s1_trig,
  output logic [15:0] echo_us,
  output logic [9:0]  dist_cm,
  output logic        dist_vld,
  output logic        err_to,
  output logic        busy
);

  localparam int MAX_A = (TRIG_US > WAIT_US) ? TRIG_US : WAIT_US;
  localparam int MAX_C = (MAX_A > ECHO_MAX_US) ? MAX_A : ECHO_MAX_US;
  localparam int CW    = $clog2(MAX_C + 2);
  localparam int PW    = $clog2(PERIOD_US + 2);
  localparam logic [15:0] DIVISOR = 16'd58;
  localparam logic [9:0]  QMAX    = 10'd1023;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEAS, DIV, HOLD} state_t;

  state_t state, state_nxt;

  logic          echo_s1, echo_s2, echo_d;
  logic [CW-1:0] cnt;
  logic [PW-1:0] per_cnt;
  logic [15:0]   rem;
  logic [9:0]    quo;

  logic echo_rise, trig_done, wait_fail, meas_fail, meas_end, div_done, hold_done;

  // The rise detector tracks the echo continuously, so a level already high on WAIT_RISE entry is not a rise.
  assign echo_rise = echo_s2 & ~echo_d;
  assign trig_done = (state == TRIG) && (cnt == CW'(TRIG_US - 1));
  assign wait_fail = (state == WAIT_RISE) && !echo_rise && (cnt == CW'(WAIT_US - 1));
  assign meas_fail = (state == MEAS) && (cnt >= CW'(ECHO_MAX_US));
  assign meas_end  = (state == MEAS) && !meas_fail && !echo_s2;
  assign div_done  = (state == DIV) && (rem < DIVISOR);
  assign hold_done = (state == HOLD) && (per_cnt >= PW'(PERIOD_US - 1));

  always_ff @(posedge clk_1m) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start || auto_en) state_nxt = TRIG;
      TRIG:      if (trig_done) state_nxt = WAIT_RISE;
      WAIT_RISE: begin
        if (echo_rise)      state_nxt = MEAS;
        else if (wait_fail) state_nxt = HOLD;
      end
      MEAS: begin
        if (meas_fail)     state_nxt = HOLD;
        else if (meas_end) state_nxt = DIV;
      end
      DIV:       if (div_done) state_nxt = HOLD;
      HOLD:      if (hold_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s1_trig = (state == TRIG);
    busy    = (state != IDLE);
  end

  // The rise cycle itself is counted, hence the width counter restarts at 1.
  always_ff @(posedge clk_1m) begin
    if (!rst_n) begin
      echo_s1  <= 1'b0;
      echo_s2  <= 1'b0;
      echo_d   <= 1'b0;
      cnt      <= '0;
      per_cnt  <= '0;
      rem      <= '0;
      quo      <= '0;
      echo_us  <= '0;
      dist_cm  <= '0;
      dist_vld <= 1'b0;
      err_to   <= 1'b0;
    end else begin
      echo_s1  <= s1_echo;
      echo_s2  <= echo_s1;
      echo_d   <= echo_s2;
      dist_vld <= 1'b0;

      if (state == IDLE)                 per_cnt <= '0;
      else if (per_cnt < PW'(PERIOD_US)) per_cnt <= per_cnt + PW'(1);

      case (state)
        IDLE:      cnt <= '0;
        TRIG:      cnt <= trig_done ? '0 : cnt + CW'(1);
        WAIT_RISE: cnt <= echo_rise ? CW'(1) : cnt + CW'(1);
        MEAS:      if (echo_s2 && !meas_fail) cnt <= cnt + CW'(1);
        default:   ;
      endcase

      if (meas_end) begin
        echo_us <= 16'(cnt);
        rem     <= 16'(cnt);
        quo     <= '0;
      end

      if ((state == DIV) && !div_done) begin
        rem <= rem - DIVISOR;
        if (quo != QMAX) quo <= quo + 10'd1;
      end

      if (div_done) begin
        dist_vld <= 1'b1;
        err_to   <= 1'b0;
        dist_cm  <= quo;
      end

      if (wait_fail || meas_fail) begin
        dist_vld <= 1'b1;
        err_to   <= 1'b1;
        dist_cm  <= QMAX;
        echo_us  <= 16'(cnt);
      end
    end
  end

endmodule

// File: doc/sr04_ranger.md
SR04_RANGER -- requirements
Module: sr04_ranger

Interface
REQ-001 Parameter TRIG_US, default 10: trigger pulse width, in clk_1m cycles.
REQ-002 Parameter WAIT_US, default 30000: maximum wait for the echo rising edge after trigger falls.
REQ-003 Parameter ECHO_MAX_US, default 38000: maximum echo high time; reaching it counts as no-target.
REQ-004 Parameter PERIOD_US, default 60000: minimum interval from one trigger rise to the next trigger rise.
REQ-005 clk_1m  input  1: 1 MHz clock; one cycle = 1 us; the only clock.
REQ-006 rst_n  input  1: reset, synchronous, active-low.
REQ-007 start  input  1: single-cycle measurement request; honoured only in IDLE.
REQ-008 auto_en  input  1: free-run mode; when high, a new measurement starts automatically.
REQ-009 s1_echo  input  1: asynchronous echo from the sensor.
REQ-010 s1_trig  output  1: trigger to the sensor.
REQ-011 echo_us  output  16: last measured echo width in us.
REQ-012 dist_cm  output  10: last distance in cm.
REQ-013 dist_vld  output  1: single-cycle pulse when echo_us, dist_cm and err_to update.
REQ-014 err_to  output  1: last measurement failed (no echo, or echo too long).
REQ-015 busy  output  1: high whenever the state is not IDLE.

Function
REQ-016 s1_echo SHALL pass through a 2-flop synchronizer; all echo decisions use the synchronized value.
  - Synchronizer adds 2 cycles of delay to both edges.
  - Measured width is unaffected.
REQ-017 States: IDLE, TRIG, WAIT_RISE, MEAS, DIV, HOLD.
REQ-018 IDLE -> TRIG on the cycle after start=1 or auto_en=1 is sampled.
REQ-019 TRIG: s1_trig=1 for exactly TRIG_US cycles, then -> WAIT_RISE.
REQ-020 WAIT_RISE: a cycle counter runs from 0.
  - Synchronized echo rises: -> MEAS, width counter cleared.
  - Counter reaches WAIT_US-1 with no rise: timeout fail (REQ-023).
REQ-021 MEAS: width counter increments each cycle the synchronized echo is high.
  - Echo falls: echo_us <= count, -> DIV.
  - Count reaches ECHO_MAX_US: fail (REQ-023).
REQ-022 DIV: dist_cm = floor(echo_us/58), by iterative subtraction.
  - One subtraction of 58 per cycle.
  - Quotient saturates at 1023.
  - When done: dist_vld=1 for one cycle, err_to=0, -> HOLD.
  - Example: width 580 takes 11 DIV cycles.
REQ-023 Fail path, one cycle after the fail condition:
  - dist_vld=1 for one cycle, err_to=1, dist_cm=1023.
  - echo_us = count reached at failure.
  - -> HOLD.
REQ-024 HOLD: stay until PERIOD_US cycles have elapsed since s1_trig rose, then -> IDLE.
  - Back-to-back triggers (auto_en, or start asserted on the first IDLE cycle) are spaced PERIOD_US+1 cycles apart.
REQ-025 start in any non-IDLE state SHALL be ignored; no queuing.
REQ-026 err_to, echo_us and dist_cm SHALL hold their values between dist_vld pulses.
REQ-027 Echo pulses that arrive during TRIG, HOLD or IDLE SHALL be ignored.
  - An echo already high at WAIT_RISE entry does not count as a rise; a rising edge is required.
REQ-028 All counters SHALL be wide enough for PERIOD_US with no wrap-around.
REQ-029 Divider arithmetic is unsigned 16-bit.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force, at any point in any state:
  - state=IDLE, s1_trig=0, dist_vld=0, err_to=0, busy=0;
  - echo_us=0, dist_cm=0;
  - synchronizer and counters=0.
REQ-031 After reset is released, no trigger SHALL occur until start or auto_en is sampled high.

Verification
REQ-032 Bench SHALL cover these scenarios:
  - start pulse; echo 580 us high, 200 us after trigger -> s1_trig high for 10 cycles; dist_vld with echo_us=580, dist_cm=10, err_to=0.
  - echo 57 us -> dist_cm=0; echo 5800 us -> dist_cm=100; echo 37999 us -> dist_cm=655, err_to=0.
  - no echo -> dist_vld 30000 cycles after trigger fall; err_to=1, dist_cm=1023; busy stays high until 60000 cycles after trigger rise.
  - echo held high 40000 us -> err_to=1, echo_us=38000.
  - auto_en=1 held -> trigger rises exactly 60001 cycles apart; start pulses during busy produce no extra trigger.
  - rst_n low during MEAS -> next cycle all outputs 0, state IDLE; no dist_vld until a new start.
